keypad_decoder: RTL and testbench

- Consumes the raw key word from the keypad row/column scanner: upper nibble is the active-high one-hot row, lower nibble is the active-high one-hot column, and all zero means no key.
- Debounces the key and converts it to a 4-bit hex code.
- Emits exactly one press event per physical press and keeps the two most recent digits for the dual seven-segment display.
- Drives hold back to the scanner, which freezes its row counter so key_val stays stable while a key is being qualified or is held.

---
 rtl/keypad_decoder.sv | 154 +++++++++++++++
 tb/tb_keypad_decoder.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/keypad_decoder.sv
// Debounces the keypad scanner's one-hot key word, decodes it to a hex digit,
// issues one press event per physical press and keeps the last two digits.
module keypad_decoder #(
  parameter int DEBOUNCE_CYCLES = 30000,  // must be >= 2
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] key_val,
  output logic       hold,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic [3:0] curr_digit,
  output logic [3:0] prev_digit
);

  typedef enum logic [1:0] {
    IDLE,
    DEBOUNCE,
    HELD,
    RELEASE
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [7:0]       r_cand;

  logic       w_legal;
  logic       w_match;
  logic       w_zero;
  logic       w_cnt_last;
  logic [3:0] w_code;

  function automatic logic f_onehot4(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

  function automatic logic [1:0] f_bit_index(input logic [3:0] v);
    case (v)
      4'b0010: return 2'd1;
      4'b0100: return 2'd2;
      4'b1000: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  // Index is {row position, column position}; only called on a legal word.
  function automatic logic [3:0] f_decode(input logic [7:0] kv);
    logic [3:0] idx;
    idx = {f_bit_index(kv[7:4]), f_bit_index(kv[3:0])};
    case (idx)
      4'h0: return 4'h1;
      4'h1: return 4'h2;
      4'h2: return 4'h3;
      4'h3: return 4'hA;
      4'h4: return 4'h4;
      4'h5: return 4'h5;
      4'h6: return 4'h6;
      4'h7: return 4'hB;
      4'h8: return 4'h7;
      4'h9: return 4'h8;
      4'hA: return 4'h9;
      4'hB: return 4'hC;
      4'hC: return 4'hE;
      4'hD: return 4'h0;
      4'hE: return 4'hF;
      default: return 4'hD;
    endcase
  endfunction

  assign w_legal    = f_onehot4(key_val[7:4]) && f_onehot4(key_val[3:0]);
  assign w_match    = (key_val == r_cand);
  assign w_zero     = (key_val == 8'h00);
  assign w_cnt_last = (r_cnt == CNT_LAST);
  assign w_code     = f_decode(r_cand);

  // hold is registered from the next state, so it rises the cycle after the
  // first legal sample and falls the cycle after the last release sample.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_cand     <= '0;
      hold       <= 1'b0;
      key_valid  <= 1'b0;
      key_code   <= 4'h0;
      curr_digit <= 4'h0;
      prev_digit <= 4'h0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling the
      // pre-edge values, so reads of r_cnt/r_cand below see the old state.
      key_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_legal) begin
            r_cand  <= key_val;
            r_cnt   <= CNT_ONE;
            r_state <= DEBOUNCE;
            hold    <= 1'b1;
          end else begin
            hold <= 1'b0;
          end
        end

        DEBOUNCE: begin
          if (!w_match) begin
            r_cnt   <= '0;
            r_state <= IDLE;
            hold    <= 1'b0;
          end else if (w_cnt_last) begin
            r_cnt      <= '0;
            r_state    <= HELD;
            key_valid  <= 1'b1;
            key_code   <= w_code;
            prev_digit <= curr_digit;
            curr_digit <= w_code;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end

        HELD: begin
          if (w_zero) begin
            r_cnt   <= CNT_ONE;
            r_state <= RELEASE;
          end
        end

        RELEASE: begin
          if (!w_zero) begin
            r_cnt   <= '0;
            r_state <= HELD;
          end else if (w_cnt_last) begin
            r_cnt   <= '0;
            r_state <= IDLE;
            hold    <= 1'b0;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end

        default: begin
          r_cnt   <= '0;
          r_state <= IDLE;
          hold    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_decoder.sv
// Directed bench for keypad_decoder with DEBOUNCE_CYCLES=4; expected codes
// come from the row/column decode map (row = upper nibble bit, col = lower).
module tb_keypad_decoder;

  logic       clk;
  logic       reset;
  logic [7:0] key_val;
  logic       hold;
  logic       key_valid;
  logic [3:0] key_code;
  logic [3:0] curr_digit;
  logic [3:0] prev_digit;

  int n_checks = 0;
  int n_errors = 0;
  int pulses   = 0;
  int p0;

  keypad_decoder #(.DEBOUNCE_CYCLES(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .key_val    (key_val),
    .hold       (hold),
    .key_valid  (key_valid),
    .key_code   (key_code),
    .curr_digit (curr_digit),
    .prev_digit (prev_digit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (key_valid === 1'b1) pulses++;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Present one sample, let the DUT take it, and settle just after the edge.
  task automatic apply(input logic [7:0] kv);
    key_val = kv;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_n(input logic [7:0] kv, input int n);
    for (int i = 0; i < n; i++) apply(kv);
  endtask

  initial begin
    reset   = 1'b1;
    key_val = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_hold", hold, 0);
    check("rst_valid", key_valid, 0);
    check("rst_code", key_code, 0);
    check("rst_curr", curr_digit, 0);
    check("rst_prev", prev_digit, 0);
    reset = 1'b0;
    apply_n(8'h00, 2);

    // Clean press of 8'h12 (row0, col1) -> 2
    p0 = pulses;
    apply(8'h12);
    check("t1_hold_rise", hold, 1);
    check("t1_no_early_valid1", key_valid, 0);
    apply_n(8'h12, 2);
    check("t1_no_early_valid3", key_valid, 0);
    apply(8'h12);
    check("t1_valid", key_valid, 1);
    check("t1_code", key_code, 4'h2);
    check("t1_curr", curr_digit, 4'h2);
    check("t1_prev", prev_digit, 4'h0);
    apply(8'h00);
    check("t1_valid_width", key_valid, 0);
    check("t1_code_held", key_code, 4'h2);
    apply_n(8'h00, 2);
    check("t1_hold_3zeros", hold, 1);
    apply(8'h00);
    check("t1_hold_fall", hold, 0);
    check("t1_pulses", pulses - p0, 1);

    // Bounce on press with 8'h84 (row3, col2) -> F
    p0 = pulses;
    apply_n(8'h84, 2);
    check("t2_hold_burst", hold, 1);
    apply(8'h00);
    check("t2_hold_bounce", hold, 0);
    apply_n(8'h84, 3);
    check("t2_no_early_valid", key_valid, 0);
    apply(8'h84);
    check("t2_valid", key_valid, 1);
    check("t2_code", key_code, 4'hF);
    check("t2_curr", curr_digit, 4'hF);
    check("t2_prev", prev_digit, 4'h2);
    apply_n(8'h00, 4);
    check("t2_hold_fall", hold, 0);
    check("t2_pulses", pulses - p0, 1);

    // Long hold of 8'h21 (row1, col0) -> 4, with a release glitch
    p0 = pulses;
    apply_n(8'h21, 4);
    check("t3_code", key_code, 4'h4);
    apply_n(8'h21, 16);
    apply_n(8'h00, 2);
    apply(8'h21);
    check("t3_hold_glitch", hold, 1);
    apply_n(8'h00, 3);
    check("t3_hold_3zeros", hold, 1);
    apply(8'h00);
    check("t3_hold_fall", hold, 0);
    check("t3_pulses", pulses - p0, 1);
    check("t3_curr", curr_digit, 4'h4);
    check("t3_prev", prev_digit, 4'hF);

    // Illegal words in IDLE, then a second key while HELD on 8'h11 -> 1
    p0 = pulses;
    apply(8'h13);
    check("t4_hold_13", hold, 0);
    apply(8'h30);
    check("t4_hold_30", hold, 0);
    check("t4_illegal_pulses", pulses - p0, 0);
    apply_n(8'h11, 4);
    check("t4_code", key_code, 4'h1);
    apply_n(8'h18, 3);
    check("t4_hold_other", hold, 1);
    check("t4_valid_other", key_valid, 0);
    apply_n(8'h00, 4);
    check("t4_hold_fall", hold, 0);
    check("t4_pulses", pulses - p0, 1);
    check("t4_curr", curr_digit, 4'h1);
    check("t4_prev", prev_digit, 4'h4);

    // Reset during DEBOUNCE on 8'h48 (row2, col3) -> C
    p0 = pulses;
    apply_n(8'h48, 2);
    check("t5_hold_pre", hold, 1);
    #2 reset = 1'b1;
    #1;
    check("t5_rst_hold", hold, 0);
    check("t5_rst_code", key_code, 0);
    check("t5_rst_curr", curr_digit, 0);
    check("t5_rst_prev", prev_digit, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    apply_n(8'h48, 3);
    check("t5_no_early_valid", key_valid, 0);
    check("t5_mid_pulses", pulses - p0, 0);
    apply(8'h48);
    check("t5_valid", key_valid, 1);
    check("t5_code", key_code, 4'hC);
    check("t5_curr", curr_digit, 4'hC);
    check("t5_prev", prev_digit, 4'h0);
    apply_n(8'h00, 4);
    check("t5_hold_fall", hold, 0);
    check("t5_pulses", pulses - p0, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
